// File: rtl/instruction_memory_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_fetch
// Brief    : Synchronous-read instruction memory for the CPU fetch stage.
//            It has a valid/ready fetch handshake with one-cycle latency, a
//            runtime program-load port, and fault reporting for misaligned
//            or out-of-range fetches. After every reset, a clear sweep
//            fills the whole array with NOP (all zeros).
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_fetch #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  parameter  int MEM_DEPTH  = 256,
  localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch request channel
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [ADDR_WIDTH-1:0] Req_Address,
  // fetch response channel
  output logic                  Resp_Valid,
  input  logic                  Resp_Ready,
  output logic [DATA_WIDTH-1:0] Resp_Instruction,
  output logic                  Resp_Fault,
  // program-load port
  input  logic                  Load_En,
  input  logic [IDX_W-1:0]      Load_Index,
  input  logic [DATA_WIDTH-1:0] Load_Data,
  output logic                  Load_Ready,
  // status
  output logic                  Busy,
  output logic [31:0]           Fetch_Count
);

  // The last word index. Writing this index ends the clear sweep.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        clear_idx;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    running;
  logic                    accept;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    fault;
  logic [IDX_W-1:0]        fetch_idx;

  // The word index comes from the byte address. The two low bits only
  // matter for the alignment check.
  assign fetch_idx  = Req_Address[IDX_W+1:2];
  assign misaligned = |Req_Address[1:0];

  // Any address bit above the word-index field means the address is past
  // the end of the array. If the address is exactly as wide as the index
  // plus the byte offset, no address can be out of range.
  if (ADDR_WIDTH > IDX_W + 2) begin : g_range_check
    assign out_of_range = |Req_Address[ADDR_WIDTH-1:IDX_W+2];
  end else begin : g_no_range_check
    assign out_of_range = 1'b0;
  end

  assign fault   = misaligned | out_of_range;
  assign running = (state == ST_RUN);

  // A new request may enter when the response slot is empty or is
  // draining this cycle. This keeps a full-rate stream while Resp_Ready
  // stays high.
  assign Req_Ready  = running && (!Resp_Valid || Resp_Ready);
  assign accept     = Req_Valid && Req_Ready;
  assign Load_Ready = running;
  assign Busy       = !running;

  // Sequencer: sweep every word to NOP after reset, then serve requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clear_idx <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clear_idx <= clear_idx + IDX_ONE;
          if (clear_idx == LAST_IDX) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state     <= ST_CLEAR;
          clear_idx <= '0;
        end
      endcase
    end
  end

  // Memory write port: the clear sweep owns it during CLEAR, and the load
  // port owns it during RUN. Fetch reads use the pre-edge contents, so a
  // load and a fetch of the same word in one cycle return the old word.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clear_idx] <= '0;
    end else if (Load_En) begin
      mem[Load_Index] <= Load_Data;
    end
  end

  // Response register: load on accept, drop valid once it is consumed, and
  // hold everything stable while it is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      Resp_Valid       <= 1'b0;
      Resp_Instruction <= '0;
      Resp_Fault       <= 1'b0;
    end else if (accept) begin
      Resp_Valid       <= 1'b1;
      Resp_Fault       <= fault;
      Resp_Instruction <= fault ? '0 : mem[fetch_idx];
    end else if (Resp_Ready) begin
      Resp_Valid       <= 1'b0;
    end
  end

  // Count accepted requests, faulting ones included. The counter wraps at
  // 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      Fetch_Count <= 32'd0;
    end else if (accept) begin
      Fetch_Count <= Fetch_Count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory_fetch
// Brief    : Self-checking bench for instruction_memory_fetch. A table of
//            directed load/fetch vectors is applied in a loop. Hand-written
//            sequences cover the clear sweep, back-pressure, a load and
//            fetch in the same cycle, and reset in the middle of a stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_fetch;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int MEM_DEPTH  = 256;
  localparam int IDX_W      = 8;
  localparam int TIMEOUT    = 400;

  logic                  clk;
  logic                  rst;
  logic                  Req_Valid;
  logic                  Req_Ready;
  logic [ADDR_WIDTH-1:0] Req_Address;
  logic                  Resp_Valid;
  logic                  Resp_Ready;
  logic [DATA_WIDTH-1:0] Resp_Instruction;
  logic                  Resp_Fault;
  logic                  Load_En;
  logic [IDX_W-1:0]      Load_Index;
  logic [DATA_WIDTH-1:0] Load_Data;
  logic                  Load_Ready;
  logic                  Busy;
  logic [31:0]           Fetch_Count;

  instruction_memory_fetch #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Req_Valid        (Req_Valid),
    .Req_Ready        (Req_Ready),
    .Req_Address      (Req_Address),
    .Resp_Valid       (Resp_Valid),
    .Resp_Ready       (Resp_Ready),
    .Resp_Instruction (Resp_Instruction),
    .Resp_Fault       (Resp_Fault),
    .Load_En          (Load_En),
    .Load_Index       (Load_Index),
    .Load_Data        (Load_Data),
    .Load_Ready       (Load_Ready),
    .Busy             (Busy),
    .Fetch_Count      (Fetch_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             do_load;
    logic [IDX_W-1:0] load_idx;
    logic [31:0]      load_data;
    logic [31:0]      addr;
    logic [31:0]      exp_instr;
    logic             exp_fault;
    string            name;
  } vec_t;

  vec_t        vecs [10];
  int          checks;
  int          errors;
  logic [31:0] exp_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Drives one load for a single edge and returns at
  // the next negedge.
  task automatic do_load(input logic [IDX_W-1:0] idx, input logic [31:0] data);
    Load_En    = 1'b1;
    Load_Index = idx;
    Load_Data  = data;
    @(posedge clk);
    @(negedge clk);
    Load_En    = 1'b0;
  endtask

  // Called at a negedge. Issues one fetch with Resp_Ready high, then checks
  // the response at the negedge after acceptance.
  task automatic fetch_check(input string name, input logic [31:0] addr,
                             input logic [31:0] exp_i, input logic exp_f);
    int n;
    Req_Valid   = 1'b1;
    Req_Address = addr;
    Resp_Ready  = 1'b1;
    n = 0;
    #1;
    while (!Req_Ready && n < TIMEOUT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, " req_ready_timeout"}, 64'(Req_Ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    Req_Valid = 1'b0;
    exp_count = exp_count + 32'd1;
    check({name, " resp_valid"}, 64'(Resp_Valid), 64'(1));
    check({name, " instr"},      64'(Resp_Instruction), 64'(exp_i));
    check({name, " fault"},      64'(Resp_Fault), 64'(exp_f));
    check({name, " count"},      64'(Fetch_Count), 64'(exp_count));
  endtask

  // Called at a negedge. Waits for the clear sweep to finish, up to a
  // cycle bound, and returns how many sampled cycles showed Busy high.
  task automatic wait_sweep(output int busy_cycles);
    busy_cycles = 0;
    while (Busy && busy_cycles < TIMEOUT) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          cycles;
    int          hold;
    int          held_cycles;
    int          issued;
    logic        held;
    logic        acc;
    logic [31:0] got [$];

    checks      = 0;
    errors      = 0;
    exp_count   = 32'd0;
    rst         = 1'b1;
    Req_Valid   = 1'b0;
    Req_Address = '0;
    Resp_Ready  = 1'b0;
    Load_En     = 1'b0;
    Load_Index  = '0;
    Load_Data   = '0;

    vecs[0] = '{1'b0, 8'd0,   32'h0,        32'h0000_0000, 32'h0,        1'b0, "v0_zero"};
    vecs[1] = '{1'b1, 8'd5,   32'h0880_3000, 32'h0000_0014, 32'h0880_3000, 1'b0, "v1_load5"};
    vecs[2] = '{1'b0, 8'd0,   32'h0,        32'h0000_0006, 32'h0,        1'b1, "v2_misal6"};
    vecs[3] = '{1'b0, 8'd0,   32'h0,        32'h0000_0400, 32'h0,        1'b1, "v3_oor400"};
    vecs[4] = '{1'b1, 8'd255, 32'hDEAD_BEEF, 32'h0000_03FC, 32'hDEAD_BEEF, 1'b0, "v4_last"};
    vecs[5] = '{1'b1, 8'd254, 32'hCAFE_F00D, 32'h0000_03FE, 32'h0,        1'b1, "v5_misal3fe"};
    vecs[6] = '{1'b0, 8'd0,   32'h0,        32'h0000_03F8, 32'hCAFE_F00D, 1'b0, "v6_word254"};
    vecs[7] = '{1'b0, 8'd0,   32'h0,        32'h8000_0000, 32'h0,        1'b1, "v7_oor_msb"};
    vecs[8] = '{1'b1, 8'd7,   32'h0000_0011, 32'h0000_001C, 32'h0000_0011, 1'b0, "v8_load7"};
    vecs[9] = '{1'b0, 8'd0,   32'h0,        32'h0000_07FC, 32'h0,        1'b1, "v9_oor7fc"};

    // Reset for two edges, then check the reset state.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst busy",       64'(Busy), 64'(1));
    check("rst req_ready",  64'(Req_Ready), 64'(0));
    check("rst load_ready", 64'(Load_Ready), 64'(0));
    check("rst resp_valid", 64'(Resp_Valid), 64'(0));
    check("rst instr",      64'(Resp_Instruction), 64'(0));
    check("rst fault",      64'(Resp_Fault), 64'(0));
    check("rst count",      64'(Fetch_Count), 64'(0));
    rst = 1'b0;

    // The sweep should take exactly MEM_DEPTH cycles. Requests made
    // during the sweep must be ignored.
    Req_Valid = 1'b1;
    Load_En   = 1'b1;
    Load_Index = 8'd3;
    Load_Data  = 32'hFFFF_FFFF;
    wait_sweep(cycles);
    Req_Valid = 1'b0;
    Load_En   = 1'b0;
    check("sweep busy_cycles", 64'(cycles), 64'(MEM_DEPTH));
    #1;
    check("sweep req_ready",  64'(Req_Ready), 64'(1));
    check("sweep load_ready", 64'(Load_Ready), 64'(1));
    check("sweep count",      64'(Fetch_Count), 64'(0));
    check("sweep resp_valid", 64'(Resp_Valid), 64'(0));
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_load) do_load(vecs[i].load_idx, vecs[i].load_data);
      fetch_check(vecs[i].name, vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_fault);
    end
    fetch_check("swept_idx3", 32'h0000_000C, 32'h0, 1'b0);

    // Load and fetch of word 7 in the same cycle: the fetch gets the old
    // word.
    Load_En     = 1'b1;
    Load_Index  = 8'd7;
    Load_Data   = 32'h0000_0022;
    Req_Valid   = 1'b1;
    Req_Address = 32'h0000_001C;
    Resp_Ready  = 1'b1;
    #1;
    check("same req_ready", 64'(Req_Ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    Load_En   = 1'b0;
    Req_Valid = 1'b0;
    exp_count = exp_count + 32'd1;
    check("same old_data", 64'(Resp_Instruction), 64'(32'h11));
    check("same count",    64'(Fetch_Count), 64'(exp_count));
    fetch_check("same new_data", 32'h0000_001C, 32'h0000_0022, 1'b0);

    // Stream four words, stalling the first response for 3 cycles.
    do_load(8'd0, 32'hA0);
    do_load(8'd1, 32'hA1);
    do_load(8'd2, 32'hA2);
    do_load(8'd3, 32'hA3);
    @(negedge clk);
    hold        = 0;
    held        = 1'b0;
    held_cycles = 0;
    issued      = 0;
    for (int c = 0; c < 60 && got.size() < 4; c++) begin
      if (Resp_Valid && !held) begin
        hold = 3;
        held = 1'b1;
      end
      Resp_Ready  = (hold == 0);
      Req_Valid   = (issued < 4);
      Req_Address = 32'(issued * 4);
      #1;
      if (hold > 0) begin
        held_cycles++;
        check("bp hold_instr",     64'(Resp_Instruction), 64'(32'hA0));
        check("bp hold_req_ready", 64'(Req_Ready), 64'(0));
        hold--;
      end
      acc = Req_Valid && Req_Ready;
      if (Resp_Valid && Resp_Ready) got.push_back(Resp_Instruction);
      @(posedge clk);
      if (acc) issued++;
      @(negedge clk);
    end
    Req_Valid = 1'b0;
    Resp_Ready = 1'b1;
    exp_count = exp_count + 32'd4;
    check("bp held_cycles", 64'(held_cycles), 64'(3));
    check("bp received",    64'(got.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      check("bp order", 64'((k < got.size()) ? got[k] : 32'hFFFF_FFFF), 64'(32'hA0 + k));
    end
    @(negedge clk);
    check("bp count", 64'(Fetch_Count), 64'(exp_count));

    // Reset while a response is stalled.
    Resp_Ready  = 1'b0;
    Req_Valid   = 1'b1;
    Req_Address = 32'h0000_0014;
    #1;
    check("mid req_ready", 64'(Req_Ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    Req_Valid = 1'b0;
    check("mid pending", 64'(Resp_Valid), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid resp_valid", 64'(Resp_Valid), 64'(0));
    check("mid count",      64'(Fetch_Count), 64'(0));
    check("mid busy",       64'(Busy), 64'(1));
    exp_count = 32'd0;
    wait_sweep(cycles);
    check("mid sweep_cycles", 64'(cycles), 64'(MEM_DEPTH));
    fetch_check("mid idx5_cleared",   32'h0000_0014, 32'h0, 1'b0);
    fetch_check("mid idx255_cleared", 32'h0000_03FC, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute watchdog, in case the flow stalls somewhere that no bound
  // covers.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/instruction_memory_fetch.md
Name: instruction_memory_fetch

Overview:
- Next-generation instruction memory for the CPU fetch stage. Replaces the combinational, init-only ROM with a parametrised, synchronous-read memory.
- Adds a valid/ready fetch handshake with one-cycle latency, a runtime program-load port, fault reporting for misaligned or out-of-range fetches, and a post-reset clear sweep that fills memory with NOP (all zeros).

Parameters:
- DATA_WIDTH, 32, instruction and load-data width.
- ADDR_WIDTH, 32, byte-address width of fetch requests.
- MEM_DEPTH, 256, number of words; power of two, at least 2.
- IDX_W (localparam), $clog2(MEM_DEPTH), word-index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Req_Valid  input  1  fetch request valid.
- Req_Ready  output  1  fetch request accepted when Req_Valid && Req_Ready.
- Req_Address  input  ADDR_WIDTH  byte address; word index is [IDX_W+1:2].
- Resp_Valid  output  1  response valid.
- Resp_Ready  input  1  consumer accepts response.
- Resp_Instruction  output  DATA_WIDTH  fetched word.
- Resp_Fault  output  1  request was misaligned or out of range.
- Load_En  input  1  program-load write strobe.
- Load_Index  input  IDX_W  word index to write.
- Load_Data  input  DATA_WIDTH  word to write.
- Load_Ready  output  1  load port accepting writes.
- Busy  output  1  clear sweep in progress.
- Fetch_Count  output  32  number of accepted fetch requests.

Behaviour:
- Reset: synchronous; clock and reset as stated, single clk, rst active-high synchronous. In the cycle after rst is sampled high:
  - state=CLEAR, clear index=0, Busy=1.
  - Req_Ready=0, Load_Ready=0.
  - Resp_Valid=0, Resp_Instruction=0, Resp_Fault=0, Fetch_Count=0.
- State CLEAR:
  - Each cycle writes 0 to memory[clear index], then increments the index.
  - The write to index MEM_DEPTH-1 moves the state to RUN. The sweep takes exactly MEM_DEPTH cycles after rst is released.
  - Req_Valid and Load_En are ignored.
- State RUN:
  - Busy=0 and Load_Ready=1.
  - Req_Ready = !Resp_Valid || Resp_Ready, registered-path free (combinational from Resp_Valid and Resp_Ready).
- Fetch accept: on Req_Valid && Req_Ready:
  - Next cycle: Resp_Valid=1, Resp_Instruction = memory[index] (latency 1), Resp_Fault=0.
  - Fetch_Count increments and wraps at 2^32.
- Fault cases: the request is still accepted; Resp_Fault=1 and Resp_Instruction=0 (NOP).
  - Misaligned: Req_Address[1:0] != 0.
  - Out of range: any Req_Address bit above IDX_W+1 is 1.
- Back-pressure:
  - While Resp_Valid && !Resp_Ready, Resp_Instruction and Resp_Fault hold stable and Req_Ready=0.
  - On Resp_Valid && Resp_Ready with no new accept, Resp_Valid drops next cycle.
  - Back-to-back accept with Resp_Ready held high gives a full one-word-per-cycle stream.
- Load:
  - In RUN, Load_En writes Load_Data to memory[Load_Index] at the clock edge.
  - A load is independent of the fetch handshake and may coincide with a fetch.
  - Same-cycle load and fetch of the same word: the fetch returns the old (pre-write) data. The next fetch sees the new data.
- Reset mid-operation: a pending response is dropped (Resp_Valid=0), memory is re-cleared, and Fetch_Count returns to 0.
- Memory is a plain register array, synchronous write, synchronous read into the response register. No initial-block contents are required beyond the clear sweep.

Test Plan:
- Reset clear sweep: assert rst 2 cycles, release.
  - Busy=1 for exactly 256 cycles, then Req_Ready=1.
  - A fetch of 0x0 returns 0x00000000, Resp_Fault=0.
- Load then fetch:
  - Load index 5 with 0x0880_3000, then fetch address 0x14.
  - Next cycle: Resp_Valid=1, Resp_Instruction=0x0880_3000, Fetch_Count=1.
- Streaming with back-pressure:
  - Load indices 0–3 with 0xA0..0xA3. Fetch 0x0, 0x4, 0x8, 0xC with Resp_Ready low for 3 cycles after the first response.
  - The 0xA0 response holds for 3 cycles and Req_Ready=0.
  - Order is 0xA0, 0xA1, 0xA2, 0xA3 with none lost or duplicated.
- Faults:
  - Fetch 0x6: Resp_Fault=1, instruction 0.
  - Fetch 0x400 (MEM_DEPTH=256): Resp_Fault=1, instruction 0.
  - Fetch 0x3FC: fault 0, returns memory[255].
- Same-cycle load and fetch: index 7 holds 0x11; in one cycle, load 0x22 to index 7 and fetch 0x1C.
  - That response is 0x11.
  - The next fetch of 0x1C returns 0x22.
- Reset mid-stream: assert rst while Resp_Valid=1 and Resp_Ready=0.
  - Next cycle: Resp_Valid=0, Fetch_Count=0, Busy=1.
  - After the sweep, the previously loaded index 5 reads 0.
